// File: rtl/mem_stage.sv
// LC-3b pipeline memory stage: EX/MEM latch, data-cache access FSM (incl. LDI/STI), MEM/WB latch.
// Optional result forwarding enabled by defining MEM_STAGE_FORWARD_EN.

package lc3b_pkg;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_indirect;
    logic load_regfile;
  } lc3b_control;
endpackage

module mem_stage
  import lc3b_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [width-1:0]  ex_alu_out,
  input  logic [width-1:0]  ex_ir,
  input  logic [width-1:0]  ex_pc,
  input  lc3b_control       ex_control,
  input  logic [width-1:0]  ex_store_data,
  input  logic              flush,
  output logic              stall_out,
  output logic [width-1:0]  dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [1:0]        dmem_byte_enable,
  output logic [width-1:0]  dmem_wdata,
  input  logic [width-1:0]  dmem_rdata,
  input  logic              dmem_resp,
  output logic              wb_valid,
  output logic [width-1:0]  wb_alu_out,
  output logic [width-1:0]  wb_mem_data,
  output logic [width-1:0]  wb_ir,
  output logic [width-1:0]  wb_pc,
  output lc3b_control       wb_control,
  output logic              fwd_valid,
  output logic [2:0]        fwd_reg,
  output logic [width-1:0]  fwd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2} state_t;

  state_t            state, state_next;
  logic              s_valid;
  logic [width-1:0]  s_alu_out, s_ir, s_pc, s_store_data;
  lc3b_control       s_control;
  logic [width-1:1]  ptr;
  logic [width-1:0]  load_data;
  logic              take_mem;
  logic              byte_op;
  state_t            capture_state;

  assign take_mem      = ex_valid & ~flush & (ex_control.mem_read | ex_control.mem_write);
  assign capture_state = take_mem ? ACCESS1 : IDLE;
  // Indirect pointer fetches are always word accesses
  assign byte_op       = s_control.mem_byte & ~s_control.mem_indirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and cache request; requests are held until dmem_resp
  always_comb begin
    state_next       = state;
    stall_out        = 1'b0;
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b11;
    dmem_wdata       = s_store_data;
    load_data        = dmem_rdata;
    case (state)
      IDLE: state_next = capture_state;
      ACCESS1: begin
        dmem_address = byte_op ? s_alu_out : {s_alu_out[width-1:1], 1'b0};
        dmem_read    = s_control.mem_read | s_control.mem_indirect;
        dmem_write   = s_control.mem_write & ~s_control.mem_indirect;
        if (byte_op) begin
          dmem_byte_enable = s_alu_out[0] ? 2'b10 : 2'b01;
          dmem_wdata       = {s_store_data[7:0], s_store_data[7:0]};
          load_data        = {8'h00, s_alu_out[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
        end
        stall_out = ~(dmem_resp & ~s_control.mem_indirect);
        if (dmem_resp) state_next = s_control.mem_indirect ? ACCESS2 : capture_state;
      end
      ACCESS2: begin
        dmem_address = {ptr, 1'b0};
        dmem_read    = s_control.mem_read;
        dmem_write   = s_control.mem_write;
        stall_out    = ~dmem_resp;
        if (dmem_resp) state_next = capture_state;
      end
      default: state_next = IDLE;
    endcase
  end

  // EX/MEM capture, indirect pointer and MEM/WB update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid      <= 1'b0;
      s_alu_out    <= '0;
      s_ir         <= '0;
      s_pc         <= '0;
      s_store_data <= '0;
      s_control    <= '0;
      ptr          <= '0;
      wb_valid     <= 1'b0;
      wb_alu_out   <= '0;
      wb_mem_data  <= '0;
      wb_ir        <= '0;
      wb_pc        <= '0;
      wb_control   <= '0;
    end else begin
      if (!stall_out) begin
        s_valid      <= ex_valid & ~flush;
        s_alu_out    <= ex_alu_out;
        s_ir         <= ex_ir;
        s_pc         <= ex_pc;
        s_store_data <= ex_store_data;
        s_control    <= ex_control;
      end
      if (state == ACCESS1 && dmem_resp && s_control.mem_indirect)
        ptr <= dmem_rdata[width-1:1];
      if (state == IDLE || !stall_out) begin
        wb_valid   <= (state == IDLE) ? s_valid : 1'b1;
        wb_alu_out <= s_alu_out;
        wb_ir      <= s_ir;
        wb_pc      <= s_pc;
        wb_control <= s_control;
        if (state != IDLE) wb_mem_data <= load_data;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_STAGE_FORWARD_EN
  logic s_memop;
  assign s_memop = s_control.mem_read | s_control.mem_write;

  // S has priority over W as the younger result
  always_comb begin
    fwd_valid = 1'b0;
    fwd_reg   = '0;
    fwd_data  = '0;
    if (s_valid && !s_memop && s_control.load_regfile) begin
      fwd_valid = 1'b1;
      fwd_reg   = s_ir[11:9];
      fwd_data  = s_alu_out;
    end else if (wb_valid && wb_control.load_regfile) begin
      fwd_valid = 1'b1;
      fwd_reg   = wb_ir[11:9];
      fwd_data  = wb_control.mem_read ? wb_mem_data : wb_alu_out;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads/stores, byte lanes,
// indirect accesses, flush, reset mid-access and (with MEM_STAGE_FORWARD_EN) forwarding.
module tb_mem_stage;
  import lc3b_pkg::*;

  logic        clk, reset;
  logic        ex_valid, flush, dmem_resp;
  logic [15:0] ex_alu_out, ex_ir, ex_pc, ex_store_data, dmem_rdata;
  lc3b_control ex_control, wb_control;
  logic        stall_out, dmem_read, dmem_write, wb_valid, fwd_valid;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_address, dmem_wdata, wb_alu_out, wb_mem_data, wb_ir, wb_pc, fwd_data;
  logic [2:0]  fwd_reg;

  int total = 0;
  int bad   = 0;

  mem_stage #(.width(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_ir(ex_ir),
    .ex_pc(ex_pc), .ex_control(ex_control), .ex_store_data(ex_store_data), .flush(flush),
    .stall_out(stall_out), .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .wb_valid(wb_valid),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_ir(wb_ir), .wb_pc(wb_pc),
    .wb_control(wb_control), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic lc3b_control ctl(input logic rd, input logic wr, input logic byt,
                                      input logic ind, input logic ld);
    lc3b_control c;
    c.mem_read = rd; c.mem_write = wr; c.mem_byte = byt; c.mem_indirect = ind; c.load_regfile = ld;
    return c;
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Present one bundle for one cycle while the stage is idle
  task automatic send(input string tag, input logic [15:0] alu, input logic [15:0] ir,
                      input logic [15:0] sd, input lc3b_control c);
    ex_valid = 1'b1; ex_alu_out = alu; ex_ir = ir; ex_pc = 16'h0100; ex_store_data = sd;
    ex_control = c;
    @(negedge clk);
    check({tag, ".pre_idle"}, {stall_out, dmem_read, dmem_write}, 3'b000);
    next_cycle();
    ex_valid = 1'b0; ex_control = '0;
  endtask

  // One cache phase: waits cycles without resp, then one cycle with resp
  task automatic phase(input string tag, input int waits, input logic [15:0] rdata,
                       input logic [15:0] addr, input logic rd, input logic wr,
                       input logic [1:0] be, input logic [15:0] wdata, input logic stall_end);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check({tag, ".wait"}, {stall_out, dmem_address, dmem_read, dmem_write},
            {1'b1, addr, rd, wr});
      next_cycle();
    end
    dmem_resp = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    check({tag, ".resp"}, {stall_out, dmem_address, dmem_read, dmem_write},
          {stall_end, addr, rd, wr});
    if (wr) check({tag, ".wdata"}, {dmem_byte_enable, dmem_wdata}, {be, wdata});
    next_cycle();
    dmem_resp = 1'b0; dmem_rdata = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; flush = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    ex_alu_out = '0; ex_ir = '0; ex_pc = '0; ex_store_data = '0; ex_control = '0;
    @(posedge clk); #1;
    check("reset", {stall_out, dmem_read, dmem_write, wb_valid, fwd_valid}, 5'b00000);
    check("reset.wb", {wb_alu_out, wb_mem_data}, 32'h0);
    next_cycle();
    reset = 1'b0;
    idle(1);

    // ADD R3: wb two cycles after ex
    send("add", 16'h0042, 16'h16E1, 16'h0000, ctl(0, 0, 0, 0, 1));
    @(negedge clk);
    check("add.s", {stall_out, dmem_read, dmem_write, wb_valid}, 4'b0000);
    next_cycle();
    @(negedge clk);
    check("add.wb", {wb_valid, wb_alu_out, wb_pc}, {1'b1, 16'h0042, 16'h0100});
    next_cycle();
    @(negedge clk);
    check("add.bubble", wb_valid, 1'b0);
    idle(1);

    // LDR R2, 3 wait states
    send("ldr", 16'h1001, 16'h6440, 16'h0000, ctl(1, 0, 0, 0, 1));
    phase("ldr", 3, 16'hBEEF, 16'h1000, 1, 0, 2'b11, 16'h0000, 0);
    @(negedge clk);
    check("ldr.wb", {wb_valid, wb_mem_data, dmem_read}, {1'b1, 16'hBEEF, 1'b0});
`ifdef MEM_STAGE_FORWARD_EN
    check("ldr.fwd", {fwd_valid, fwd_reg, fwd_data}, {1'b1, 3'd2, 16'hBEEF});
`endif
    idle(2);

    // STB high lane, then LDB with zero wait states
    send("stb", 16'h2003, 16'h3000, 16'h12A5, ctl(0, 1, 1, 0, 0));
    phase("stb", 2, 16'h0000, 16'h2003, 0, 1, 2'b10, 16'hA5A5, 0);
    @(negedge clk);
    check("stb.wb", {wb_valid, dmem_write}, 2'b10);
    idle(1);
    send("ldb", 16'h2003, 16'h2400, 16'h0000, ctl(1, 0, 1, 0, 1));
    phase("ldb", 0, 16'hA500, 16'h2003, 1, 0, 2'b11, 16'h0000, 0);
    @(negedge clk);
    check("ldb.wb", {wb_valid, wb_mem_data}, {1'b1, 16'h00A5});
    idle(2);

    // LDI: pointer fetch then data read
    send("ldi", 16'h3000, 16'hA600, 16'h0000, ctl(1, 0, 0, 1, 1));
    phase("ldi1", 1, 16'h4002, 16'h3000, 1, 0, 2'b11, 16'h0000, 1);
    phase("ldi2", 2, 16'h7777, 16'h4002, 1, 0, 2'b11, 16'h0000, 0);
    @(negedge clk);
    check("ldi.wb", {wb_valid, wb_mem_data}, {1'b1, 16'h7777});
    idle(2);

    // STI: pointer fetch then word write at the (aligned) pointer
    send("sti", 16'h3000, 16'hB600, 16'h5A5A, ctl(0, 1, 0, 1, 0));
    phase("sti1", 0, 16'h4003, 16'h3000, 1, 0, 2'b11, 16'h0000, 1);
    phase("sti2", 1, 16'h0000, 16'h4002, 0, 1, 2'b11, 16'h5A5A, 0);
    @(negedge clk);
    check("sti.wb", {wb_valid, dmem_write}, 2'b10);
    idle(2);

    // Flush while idle: no access, no writeback
    ex_valid = 1'b1; flush = 1'b1; ex_alu_out = 16'h1234; ex_control = ctl(1, 0, 0, 0, 1);
    @(negedge clk);
    check("flush.idle0", dmem_read, 1'b0);
    next_cycle();
    ex_valid = 1'b0; flush = 1'b0; ex_control = '0;
    @(negedge clk);
    check("flush.idle1", {stall_out, dmem_read}, 2'b00);
    next_cycle();
    @(negedge clk);
    check("flush.idle.wb", wb_valid, 1'b0);
    idle(1);

    // Flush during ACCESS1 is ignored
    send("lflush", 16'h5000, 16'h6440, 16'h0000, ctl(1, 0, 0, 0, 1));
    ex_valid = 1'b1; flush = 1'b1; ex_control = ctl(0, 0, 0, 0, 1);
    @(negedge clk);
    check("lflush.hold", {stall_out, dmem_read, dmem_address}, {2'b11, 16'h5000});
    next_cycle();
    ex_valid = 1'b0; flush = 1'b0; ex_control = '0;
    phase("lflush", 1, 16'hCAFE, 16'h5000, 1, 0, 2'b11, 16'h0000, 0);
    @(negedge clk);
    check("lflush.wb", {wb_valid, wb_mem_data}, {1'b1, 16'hCAFE});
    idle(2);

    // Reset mid-ACCESS1: requests drop without a clock edge
    send("rst", 16'h6000, 16'h6440, 16'h0000, ctl(1, 0, 0, 0, 1));
    @(negedge clk);
    check("rst.pre", dmem_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst.async", {dmem_read, dmem_write, stall_out, wb_valid}, 4'b0000);
    @(posedge clk); #1 reset = 1'b0;
    idle(1);

    // ADD R3 = 5 visible as an S-stage forward
    send("fadd", 16'h0005, 16'h16E1, 16'h0000, ctl(0, 0, 0, 0, 1));
    @(negedge clk);
`ifdef MEM_STAGE_FORWARD_EN
    check("fwd.s", {fwd_valid, fwd_reg, fwd_data}, {1'b1, 3'd3, 16'h0005});
`else
    check("fwd.off", {fwd_valid, fwd_reg, fwd_data}, 20'h0);
`endif
    next_cycle();
    @(negedge clk);
    check("fadd.wb", {wb_valid, wb_alu_out}, {1'b1, 16'h0005});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- LC-3b pipeline memory stage: the consumer of the execute stage's outputs (alu result, ir, pc, control word).
- Latches the execute-stage outputs into an EX/MEM register.
- Runs the data-cache transaction for loads, stores and indirect accesses (LDI/STI), and presents a registered MEM/WB bundle to writeback.
- Back-pressures upstream with stall_out while a cache access is outstanding.

Parameters:
- width, 16, datapath word width (only 16 supported).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute-stage bundle is a real instruction (0 = bubble)
- ex_alu_out  in  16  execute-stage ALU result (effective address for memory ops)
- ex_ir  in  16  instruction word
- ex_pc  in  16  instruction pc
- ex_control  in  lc3b_control  control word; fields read here: mem_read, mem_write, mem_byte, mem_indirect, load_regfile
- ex_store_data  in  16  store source register value
- flush  in  1  discard the incoming execute bundle
- stall_out  out  1  stage busy; upstream must hold its bundle
- dmem_address  out  16  data-cache address
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_byte_enable  out  2  write byte lanes
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data
- dmem_resp  in  1  cache transaction complete
- wb_valid  out  1  MEM/WB bundle valid
- wb_alu_out, wb_mem_data, wb_ir, wb_pc  out  16 each  MEM/WB fields
- wb_control  out  lc3b_control  MEM/WB control word
- fwd_valid  out  1  forwarding result valid (see Optional Feature)
- fwd_reg  out  3  forwarding destination register
- fwd_data  out  16  forwarding value

Behaviour:
- Registers:
  - S: EX/MEM latch holding valid, alu_out, ir, pc, control, store_data.
  - ptr: 16-bit indirect pointer.
  - state: IDLE, ACCESS1, ACCESS2.
  - W: MEM/WB latch.
- Reset (async): S.valid=0, W.valid=0, state=IDLE, ptr=0, all W fields 0. dmem_read=dmem_write=0 and stall_out=0 immediately (all combinational from state).
- memop = S.control.mem_read | S.control.mem_write.
- stall_out:
  - 1 in ACCESS1 unless (dmem_resp & !mem_indirect);
  - 1 in ACCESS2 unless dmem_resp;
  - 0 in IDLE.
- Capture, on an edge with stall_out=0:
  - S <= ex bundle; S.valid <= ex_valid & !flush.
  - If the new bundle is valid and is a memop, state <= ACCESS1.
- ACCESS1:
  - Address = S.alu_out; word accesses force bit0=0.
  - Read asserted if mem_read or mem_indirect; write asserted if mem_write & !mem_indirect.
  - On dmem_resp with mem_indirect: ptr <= dmem_rdata, state <= ACCESS2.
  - On dmem_resp without mem_indirect: state <= IDLE, W captures.
- ACCESS2:
  - Address = ptr with bit0=0; read for LDI, write for STI.
  - On dmem_resp: state <= IDLE, W captures.
- Request signals stay asserted, with address and data stable, until dmem_resp.
- Byte ops (mem_byte):
  - Store: byte_enable = addr[0] ? 2'b10 : 2'b01; wdata = {store_data[7:0], store_data[7:0]}.
  - Load: mem_data = zero-extended rdata byte selected by addr[0].
- Word ops: byte_enable = 2'b11, wdata = store_data.
- W update each edge:
  - In IDLE: W <= S (non-memory or bubble), wb_mem_data unchanged.
  - On access completion: W <= S, wb_mem_data <= load result, wb_valid = 1.
  - While stalled: W.valid <= 0 (bubble to writeback).
- Latency:
  - Non-memory op: ex at cycle t, wb_valid at t+2.
  - Memory op: wb_valid the cycle after the final dmem_resp.
- Boundary conditions:
  - dmem_resp in the same cycle as the request is legal and gives zero wait states.
  - flush while stall_out=1 is ignored; the access in flight is never aborted.
  - ex_valid=0 produces no dmem activity.
  - Reset mid-access drops the transaction; requests deassert asynchronously.

Optional Feature:
- Macro MEM_STAGE_FORWARD_EN.
- Defined:
  - First priority, from S: when S.valid & !memop & load_regfile, fwd_valid=1, fwd_reg=S.ir[11:9], fwd_data=S.alu_out.
  - Otherwise, from W: when wb_valid & load_regfile, fwd_valid=1, fwd_reg=wb_ir[11:9], fwd_data = mem_read ? wb_mem_data : wb_alu_out.
  - Otherwise fwd_valid=0.
- Undefined: fwd_valid, fwd_reg and fwd_data tied to 0.

Test Plan:
- ADD bundle (alu_out=16'h0042, load_regfile=1), no memory -> stall_out stays 0, dmem idle, wb_valid=1 with wb_alu_out=16'h0042 two cycles after ex_valid.
- LDR alu_out=16'h1001, dmem_resp after 3 cycles with rdata=16'hBEEF -> dmem_address=16'h1000, stall_out high 3 cycles, wb_mem_data=16'hBEEF.
- STB alu_out=16'h2003, store_data=16'h12A5 -> byte_enable=2'b10, wdata=16'hA5A5, dmem_write held until resp; LDB alu_out=16'h2003, rdata=16'hA500 -> wb_mem_data=16'h00A5.
- LDI alu_out=16'h3000, first rdata=16'h4002, second rdata=16'h7777 -> second read at 16'h4002, wb_mem_data=16'h7777; STI the same way ends with a write at the pointer.
- flush=1 with ex_valid=1 while IDLE -> no dmem activity, wb_valid=0 next cycle; flush during ACCESS1 -> access completes normally.
- reset asserted mid-ACCESS1 -> dmem_read drops without a clock edge, wb_valid=0, stall_out=0; with MEM_STAGE_FORWARD_EN, an ADD to R3 (alu_out=16'h0005) gives fwd_reg=3, fwd_data=16'h0005 while in S.
